// File: rtl/au_int_exp2_seq.sv
// Sequential z = 2^a generator, one exponent bit applied per BUSY cycle.
// Define AU_INT_EXP2_SAT_EN to saturate z to all ones on overflow.
module au_int_exp2_seq #(
  parameter int WIDTH = 8,
  localparam int EW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EW-1:0]    a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             ovf
);

  localparam int KW = (EW > 1) ? $clog2(EW) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(EW - 1);

`ifdef AU_INT_EXP2_SAT_EN
  localparam logic [WIDTH-1:0] OVF_Z = '1;
`else
  localparam logic [WIDTH-1:0] OVF_Z = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [EW-1:0]    r_a;
  logic [WIDTH-1:0] r_acc;
  logic [KW-1:0]    r_k;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_z;
  logic             r_ovf_o;

  logic [WIDTH-1:0] w_shift;
  logic             w_ovf;

  // Shift amounts of WIDTH or more naturally clear the accumulator.
  assign w_shift = r_a[r_k] ? (r_acc << (32'd1 << r_k)) : r_acc;
  assign w_ovf   = 32'(a) >= 32'(WIDTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_acc       <= '0;
      r_k         <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_z         <= '0;
      r_ovf_o     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_acc      <= WIDTH'(1);
            r_k        <= '0;
            r_ovf      <= w_ovf;
            r_in_ready <= 1'b0;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc <= w_shift;
          r_k   <= r_k + 1'b1;
          if (r_k == K_LAST) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_z         <= r_ovf ? OVF_Z : w_shift;
            r_ovf_o     <= r_ovf;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_z         <= '0;
            r_ovf_o     <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign z         = r_z;
  assign ovf       = r_ovf_o;

endmodule

// File: tb/tb_au_int_exp2_seq.sv
// Randomized bench for au_int_exp2_seq at WIDTH 8, 10 and 1.
// Expected results come from plain 2^a arithmetic and cycle counting.
module tb_au_int_exp2_seq;

`ifdef AU_INT_EXP2_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam int W [3] = '{8, 10, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] iv = '0;
  logic [2:0] ordy = '1;
  logic [2:0][3:0] av = '0;
  logic [2:0] irdy;
  logic [2:0] ovld;
  logic [2:0] ovfw;
  logic [7:0] z8;
  logic [9:0] z10;
  logic       z1;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  au_int_exp2_seq #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(irdy[0]), .a(av[0][2:0]),
    .out_valid(ovld[0]), .out_ready(ordy[0]),
    .z(z8), .ovf(ovfw[0])
  );

  au_int_exp2_seq #(.WIDTH(10)) u_w10 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(irdy[1]), .a(av[1][3:0]),
    .out_valid(ovld[1]), .out_ready(ordy[1]),
    .z(z10), .ovf(ovfw[1])
  );

  au_int_exp2_seq #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[2]), .in_ready(irdy[2]), .a(av[2][0:0]),
    .out_valid(ovld[2]), .out_ready(ordy[2]),
    .z(z1), .ovf(ovfw[2])
  );

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic int ew(input int w);
    int e = 0;
    while ((1 << e) < w) e++;
    return (e < 1) ? 1 : e;
  endfunction

  function automatic longint exp_z(input int w, input int x);
    if (x >= w) return SAT ? ((64'd1 << w) - 1) : 0;
    return 64'd1 << x;
  endfunction

  function automatic longint zr(input int i);
    case (i)
      0: return longint'(z8);
      1: return longint'(z10);
      default: return longint'(z1);
    endcase
  endfunction

  task automatic job(input int i, input int x, input int stall);
    int n;
    int w;
    longint zx;
    w = W[i];
    zx = exp_z(w, x);
    check("in_ready_idle", irdy[i], 1);
    iv[i] = 1'b1;
    av[i] = 4'(x);
    @(negedge clk);
    acc_cyc = cyc;
    iv[i] = 1'b0;
    av[i] = 4'($urandom);
    if (stall > 0) ordy[i] = 1'b0;
    check("in_ready_busy", irdy[i], 0);
    n = 0;
    while (!ovld[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, ew(w));
    check("z", zr(i), zx);
    check("ovf", ovfw[i], (x >= w) ? 1 : 0);
    for (int s = 0; s < stall; s++) begin
      iv[i] = 1'b1;
      av[i] = 4'd1;
      @(negedge clk);
      check("hold_valid", ovld[i], 1);
      check("hold_z", zr(i), zx);
      check("hold_rdy", irdy[i], 0);
    end
    iv[i] = 1'b0;
    ordy[i] = 1'b1;
    @(negedge clk);
    check("out_done", ovld[i], 0);
    check("rdy_after", irdy[i], 1);
    check("z_idle", zr(i), 0);
    check("ovf_idle", ovfw[i], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", irdy[i], 1);
      check("rst_out_valid", ovld[i], 0);
      check("rst_z", zr(i), 0);
      check("rst_ovf", ovfw[i], 0);
    end

    iv[0] = 1'b1;
    av[0] = 4'd3;
    @(negedge clk);
    rst = 1'b0;
    iv[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_win_valid", ovld[0], 0);
    check("rst_win_rdy", irdy[0], 1);

    job(0, 3, 0);

    for (int x = 0; x < 8; x++) begin
      prev = acc_cyc;
      job(0, x, 0);
      if (x > 0) check("interval", acc_cyc - prev, 5);
    end

    job(1, 12, 0);
    job(1, 9, 0);

    job(0, 5, 10);
    repeat (3) begin
      @(negedge clk);
      check("one_result", ovld[0], 0);
    end

    check("mid_rst_idle", irdy[0], 1);
    iv[0] = 1'b1;
    av[0] = 4'd7;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_rdy", irdy[0], 1);
    check("mid_rst_valid", ovld[0], 0);
    check("mid_rst_z", zr(0), 0);
    repeat (5) begin
      @(negedge clk);
      check("mid_rst_quiet", ovld[0], 0);
    end
    job(0, 2, 0);

    job(2, 0, 0);
    job(2, 1, 0);
    job(2, 1, 2);

    for (int r = 0; r < 40; r++) begin
      int i;
      int x;
      i = $urandom_range(2, 0);
      x = $urandom_range((1 << ew(W[i])) - 1, 0);
      job(i, x, $urandom_range(3, 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
